microwave_timer_pwr: RTL and testbench
======================================

// Module: microwave_timer_pwr
// PURPOSE
//   Parametrised successor of the microwave controller core. Keypad time entry, countdown in
//   MM..:SS, pause/resume and door interlock. Adds selectable power level (magnetron duty
//   cycle), N minute digits, a timed DONE indication and a synchronous reset.
//   Sits between debounced board inputs (keys, buttons, door switch) and the 7-seg/magnetron outputs.
// PARAMETERS
//   MIN_DIGITS  2    number of BCD minute digits (1..3)
//   TICK_DIV    100  clk cycles per countdown second (min 2)
//   PWR_LEVELS  10   power levels 1..PWR_LEVELS; duty window = PWR_LEVELS seconds
//   DONE_SECS   3    seconds the done flag stays high before returning to SET
// PORTS
//   clk           in   1             system clock, rising edge
//   rst           in   1             synchronous, active-high reset
//   kbd           in   10            one-hot digit keys, bit n = digit n
//   startn        in   1             start/resume button, active-low
//   stopn         in   1             stop/pause button, active-low
//   clearn        in   1             clear button, active-low
//   pwr_key       in   1             power-level step button, active-high
//   door_closed   in   1             1 = door closed
//   sec_ones_seg  out  7             seconds-ones digit, segments {g..a}, active-low
//   sec_tens_seg  out  7             seconds-tens digit, same encoding
//   min_segs      out  7*MIN_DIGITS  minute digits, LS digit in [6:0]
//   pwr_seg       out  7             current power level (PWR_LEVELS=10 shows 0)
//   mag_on        out  1             magnetron enable
//   done          out  1             cooking-finished indication
//   state         out  2             0=SET 1=COOK 2=PAUSE 3=DONE
// BEHAVIOUR
//   - Reset: state=SET, time=all zero, level=PWR_LEVELS, prescaler=slot=0, mag_on=0, done=0,
//     segments show zeros.
//   - Inputs are registered once. An event is a press edge between that register and its previous
//     value. State and outputs are registered. Input change -> output change = 2 clk cycles.
//   - kbd event = 0 -> 1 transition of a one-hot value. Zero or multi-hot values are ignored.
//   - Event priority: rst > clear > door open > stop > start > pwr_key > kbd.
//   - SET state:
//     - A digit shifts the BCD field left: new digit goes to sec_ones, MS minute digit is dropped.
//     - pwr_key steps level 1..PWR_LEVELS, wrapping to 1.
//     - start with door closed and time != 0 -> COOK; prescaler and slot are cleared.
//     - start with time = 0 or door open is ignored.
//     - clear zeroes the time.
//   - COOK state:
//     - Prescaler counts 0..TICK_DIV-1. A tick fires on the wrap.
//     - Each tick decrements the time by one second:
//       - sec_ones borrows from sec_tens;
//       - SS=00 borrows one minute and becomes 59;
//       - entered tens > 5 (e.g. 0:75) counts down unnormalised.
//     - The tick that reaches all-zero -> DONE.
//     - Door open or stop -> PAUSE, with time, prescaler and slot frozen. clear -> SET with time=0.
//     - kbd and pwr_key are ignored.
//   - mag_on = (state==COOK) && door_closed && (slot < level). slot counts 0..PWR_LEVELS-1 per tick.
//   - PAUSE state:
//     - start with door closed -> COOK, resuming the frozen prescaler and slot.
//     - stop or clear -> SET with time=0.
//     - kbd, pwr_key and start with door open are ignored.
//   - DONE state:
//     - done=1, time=0. Holds for DONE_SECS ticks (prescaler keeps running), then -> SET, done=0.
//     - stop, clear or door open -> SET immediately.
//   - The power level persists across cycles; only rst restores PWR_LEVELS.
//   - rst mid-COOK/PAUSE/DONE takes effect on that edge: mag_on=0 on the next cycle.
//   - Segment decode: 0-9 standard; non-BCD values blank (7'h7F).
// TESTING (TICK_DIV=4, MIN_DIGITS=2, PWR_LEVELS=10, DONE_SECS=3)
//   - rst; keys 1,2; start -> displays 00:12, mag_on=1 two cycles after start, 00:00 after 48 cycles,
//     done=1 for 12 cycles, then SET.
//   - Keys 1,2,9; start -> 01:29, 01:28 after 1 tick; 01:00 goes to 00:59 on the next tick.
//   - pwr_key x3 from reset (wraps 10->1->2->3) -> pwr_seg=3; cooking shows mag_on 3 ticks high,
//     7 ticks low, repeating.
//   - Door opened at 00:30 -> mag_on=0 within 2 cycles, state=PAUSE, time frozen.
//     - Close door, start -> resumes from 00:30.
//     - stop in PAUSE -> SET, 00:00.
//   - start at 00:00 -> stays SET; start with door open and time 00:05 -> stays SET, mag_on=0.
//   - Keys 1,2,3,4,5 -> 23:45.
//   - kbd=10'b0000000110 ignored.
//   - rst during COOK -> SET, all zeros, level 10, next cycle.

Source files
------------

// File: rtl/microwave_timer_pwr.sv
// Microwave controller core: keypad BCD time entry, MM..:SS countdown, pause/resume,
// door interlock, power-level duty cycling of the magnetron and a timed DONE phase.
module microwave_timer_pwr #(
    parameter int MIN_DIGITS = 2,
    parameter int TICK_DIV   = 100,
    parameter int PWR_LEVELS = 10,
    parameter int DONE_SECS  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              kbd,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    clearn,
    input  logic                    pwr_key,
    input  logic                    door_closed,
    output logic [6:0]              sec_ones_seg,
    output logic [6:0]              sec_tens_seg,
    output logic [7*MIN_DIGITS-1:0] min_segs,
    output logic [6:0]              pwr_seg,
    output logic                    mag_on,
    output logic                    done,
    output logic [1:0]              state
);

    localparam int NDIG = MIN_DIGITS + 2;
    localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int LW   = $clog2(PWR_LEVELS + 1);
    localparam int DW   = $clog2(DONE_SECS + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LVL_MAX   = LW'(PWR_LEVELS);
    localparam logic [LW-1:0] SLOT_MAX  = LW'(PWR_LEVELS - 1);
    localparam logic [DW-1:0] DONE_LAST = DW'(DONE_SECS - 1);

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Registered inputs and their previous values for edge detection
    logic [9:0] kbd_q, kbd_prev_q;
    logic       start_q, start_prev_q;
    logic       stop_q, stop_prev_q;
    logic       clear_q, clear_prev_q;
    logic       pwr_q, pwr_prev_q;
    logic       door_q;

    state_t          state_q, state_d;
    logic [3:0]      digit_q [NDIG];
    logic [3:0]      digit_d [NDIG];
    logic [3:0]      digit_dec [NDIG];
    logic [PW-1:0]   presc_q, presc_d;
    logic [LW-1:0]   slot_q, slot_d;
    logic [LW-1:0]   level_q, level_d;
    logic [DW-1:0]   done_cnt_q, done_cnt_d;
    logic            mag_on_q, mag_on_d;
    logic            done_q, done_d;

    logic            start_ev, stop_ev, clear_ev, pwr_ev, kbd_ev;
    logic [3:0]      key_val;
    logic            tick;
    logic            time_zero, dec_zero;

    assign start_ev = start_prev_q & ~start_q;
    assign stop_ev  = stop_prev_q & ~stop_q;
    assign clear_ev = clear_prev_q & ~clear_q;
    assign pwr_ev   = pwr_q & ~pwr_prev_q;
    assign kbd_ev   = (kbd_prev_q == 10'd0) && $onehot(kbd_q);
    assign tick     = ((state_q == ST_COOK) || (state_q == ST_DONE)) && (presc_q == PRESC_MAX);

    always_comb begin
        key_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (kbd_q[i]) key_val = 4'(i);
        end
    end

    // One-second decrement; the seconds-tens digit borrows to 5, every other digit to 9
    always_comb begin
        logic borrow;
        borrow    = 1'b1;
        time_zero = 1'b1;
        dec_zero  = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            digit_dec[i] = digit_q[i];
            if (borrow) begin
                if (digit_q[i] == 4'd0) begin
                    digit_dec[i] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    digit_dec[i] = digit_q[i] - 4'd1;
                    borrow       = 1'b0;
                end
            end
            if (digit_q[i] != 4'd0)   time_zero = 1'b0;
            if (digit_dec[i] != 4'd0) dec_zero  = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        slot_d     = slot_q;
        level_d    = level_q;
        done_cnt_d = done_cnt_q;
        for (int i = 0; i < NDIG; i++) digit_d[i] = digit_q[i];

        case (state_q)
            ST_SET: begin
                if (clear_ev) begin
                    for (int i = 0; i < NDIG; i++) digit_d[i] = 4'd0;
                end else if (!stop_ev) begin
                    if (start_ev) begin
                        if (door_q && !time_zero) begin
                            state_d = ST_COOK;
                            presc_d = '0;
                            slot_d  = '0;
                        end
                    end else if (pwr_ev) begin
                        level_d = (level_q == LVL_MAX) ? LW'(1) : level_q + LW'(1);
                    end else if (kbd_ev) begin
                        digit_d[0] = key_val;
                        for (int i = 1; i < NDIG; i++) digit_d[i] = digit_q[i-1];
                    end
                end
            end
            ST_COOK: begin
                if (clear_ev) begin
                    state_d = ST_SET;
                    for (int i = 0; i < NDIG; i++) digit_d[i] = 4'd0;
                end else if (!door_q || stop_ev) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    presc_d = '0;
                    slot_d  = (slot_q == SLOT_MAX) ? '0 : slot_q + LW'(1);
                    for (int i = 0; i < NDIG; i++) digit_d[i] = digit_dec[i];
                    if (dec_zero) begin
                        state_d    = ST_DONE;
                        done_cnt_d = '0;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (clear_ev || stop_ev) begin
                    state_d = ST_SET;
                    for (int i = 0; i < NDIG; i++) digit_d[i] = 4'd0;
                end else if (start_ev && door_q) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (clear_ev || !door_q || stop_ev) begin
                    state_d = ST_SET;
                end else if (tick) begin
                    presc_d = '0;
                    if (done_cnt_q == DONE_LAST) state_d = ST_SET;
                    else done_cnt_d = done_cnt_q + DW'(1);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: state_d = ST_SET;
        endcase

        mag_on_d = (state_d == ST_COOK) && door_q && (slot_d < level_d);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kbd_q        <= '0;
            kbd_prev_q   <= '0;
            start_q      <= 1'b1;
            start_prev_q <= 1'b1;
            stop_q       <= 1'b1;
            stop_prev_q  <= 1'b1;
            clear_q      <= 1'b1;
            clear_prev_q <= 1'b1;
            pwr_q        <= 1'b0;
            pwr_prev_q   <= 1'b0;
            door_q       <= 1'b0;
            state_q      <= ST_SET;
            presc_q      <= '0;
            slot_q       <= '0;
            level_q      <= LVL_MAX;
            done_cnt_q   <= '0;
            mag_on_q     <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NDIG; i++) digit_q[i] <= 4'd0;
        end else begin
            kbd_q        <= kbd;
            kbd_prev_q   <= kbd_q;
            start_q      <= startn;
            start_prev_q <= start_q;
            stop_q       <= stopn;
            stop_prev_q  <= stop_q;
            clear_q      <= clearn;
            clear_prev_q <= clear_q;
            pwr_q        <= pwr_key;
            pwr_prev_q   <= pwr_q;
            door_q       <= door_closed;
            state_q      <= state_d;
            presc_q      <= presc_d;
            slot_q       <= slot_d;
            level_q      <= level_d;
            done_cnt_q   <= done_cnt_d;
            mag_on_q     <= mag_on_d;
            done_q       <= done_d;
            for (int i = 0; i < NDIG; i++) digit_q[i] <= digit_d[i];
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Level 10 fits one digit only as 0; anything larger cannot be shown and blanks
    logic [3:0] pwr_val;
    always_comb begin
        if (int'(level_q) == 10)     pwr_val = 4'd0;
        else if (int'(level_q) > 9)  pwr_val = 4'hF;
        else                         pwr_val = 4'(level_q);
    end

    assign sec_ones_seg = seg7(digit_q[0]);
    assign sec_tens_seg = seg7(digit_q[1]);
    assign pwr_seg      = seg7(pwr_val);
    assign mag_on       = mag_on_q;
    assign done         = done_q;
    assign state        = state_q;

    for (genvar gi = 0; gi < MIN_DIGITS; gi++) begin : g_min_seg
        assign min_segs[7*gi +: 7] = seg7(digit_q[gi+2]);
    end

endmodule

// File: tb/tb_microwave_timer_pwr.sv
// Scoreboard bench for microwave_timer_pwr with TICK_DIV=4, MIN_DIGITS=2, PWR_LEVELS=10, DONE_SECS=3.
module tb_microwave_timer_pwr;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  kbd;
    logic        startn, stopn, clearn, pwr_key, door_closed;
    logic [6:0]  sec_ones_seg, sec_tens_seg, pwr_seg;
    logic [13:0] min_segs;
    logic        mag_on, done;
    logic [1:0]  state;

    always #5 clk = ~clk;

    microwave_timer_pwr #(
        .MIN_DIGITS(2),
        .TICK_DIV  (4),
        .PWR_LEVELS(10),
        .DONE_SECS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .kbd         (kbd),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .pwr_key     (pwr_key),
        .door_closed (door_closed),
        .sec_ones_seg(sec_ones_seg),
        .sec_tens_seg(sec_tens_seg),
        .min_segs    (min_segs),
        .pwr_seg     (pwr_seg),
        .mag_on      (mag_on),
        .done        (done),
        .state       (state)
    );

    // Observed vector: {state, mag_on, done, pwr_seg, MM, S-tens, S-ones}
    logic [38:0] obs;
    assign obs = {state, mag_on, done, pwr_seg, min_segs, sec_tens_seg, sec_ones_seg};

    typedef struct {
        string       name;
        logic [38:0] v;
    } sb_t;

    sb_t sb_q[$];
    sb_t e;
    int  total = 0;
    int  bad   = 0;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [38:0] mk(input logic [1:0] st, input logic m, input logic dn,
                                       input logic [3:0] lvl, input logic [15:0] t);
        return {st, m, dn, seg(lvl), seg(t[15:12]), seg(t[11:8]), seg(t[7:4]), seg(t[3:0])};
    endfunction

    function automatic logic [15:0] bcd(input int v);
        return {8'h00, 4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic push_exp(input string n, input logic [38:0] v);
        sb_t s;
        s.name = n;
        s.v    = v;
        sb_q.push_back(s);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        kbd = '0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1; pwr_key = 1'b0; door_closed = 1'b1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic key(input int d);
        kbd = '0;
        kbd[d] = 1'b1;
        cyc(1);
        kbd = '0;
        cyc(1);
    endtask

    task automatic press_start();
        startn = 1'b0; cyc(1); startn = 1'b1; cyc(1);
    endtask

    task automatic press_stop();
        stopn = 1'b0; cyc(1); stopn = 1'b1; cyc(1);
    endtask

    task automatic press_clear();
        clearn = 1'b0; cyc(1); clearn = 1'b1; cyc(1);
    endtask

    task automatic press_pwr();
        pwr_key = 1'b1; cyc(1); pwr_key = 1'b0; cyc(1);
    endtask

    task automatic test_reset();
        do_reset();
        push_exp("reset_state", mk(2'd0, 1'b0, 1'b0, 4'd0, 16'h0000));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
    endtask

    task automatic test_countdown();
        do_reset();
        key(1); key(2);
        push_exp("keys_12", mk(2'd0, 1'b0, 1'b0, 4'd0, 16'h0012));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        press_start();
        push_exp("start_cook", mk(2'd1, 1'b1, 1'b0, 4'd0, 16'h0012));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        push_exp("last_second", mk(2'd1, 1'b1, 1'b0, 4'd0, 16'h0001));
        cyc(47);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        push_exp("done_enter", mk(2'd3, 1'b0, 1'b1, 4'd0, 16'h0000));
        cyc(1);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        push_exp("done_hold", mk(2'd3, 1'b0, 1'b1, 4'd0, 16'h0000));
        cyc(11);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        push_exp("done_exit", mk(2'd0, 1'b0, 1'b0, 4'd0, 16'h0000));
        cyc(1);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
    endtask

    task automatic test_minutes();
        do_reset();
        key(1); key(2); key(9);
        press_start();
        push_exp("cook_0129", mk(2'd1, 1'b1, 1'b0, 4'd0, 16'h0129));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        push_exp("tick_0128", mk(2'd1, 1'b1, 1'b0, 4'd0, 16'h0128));
        cyc(4);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        push_exp("at_0100", mk(2'd1, 1'b1, 1'b0, 4'd0, 16'h0100));
        cyc(112);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        push_exp("borrow_0059", mk(2'd1, 1'b1, 1'b0, 4'd0, 16'h0059));
        cyc(4);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        do_reset();
        key(7); key(0);
        press_start();
        push_exp("unnorm_0069", mk(2'd1, 1'b1, 1'b0, 4'd0, 16'h0069));
        cyc(4);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
    endtask

    task automatic test_power();
        do_reset();
        press_pwr(); press_pwr(); press_pwr();
        push_exp("pwr_level_3", mk(2'd0, 1'b0, 1'b0, 4'd3, 16'h0000));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        key(5); key(0);
        press_start();
        for (int k = 0; k < 20; k++) begin
            push_exp($sformatf("duty_tick%0d", k), mk(2'd1, (k % 10) < 3, 1'b0, 4'd3, bcd(50 - k)));
        end
        for (int k = 0; k < 20; k++) begin
            e = sb_q.pop_front(); total++;
            if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
            else $display("ok   %s %h", e.name, obs);
            cyc(4);
        end
    endtask

    task automatic test_door();
        do_reset();
        key(3); key(5);
        press_start();
        push_exp("cook_0030", mk(2'd1, 1'b1, 1'b0, 4'd0, 16'h0030));
        cyc(20);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        door_closed = 1'b0;
        push_exp("door_pause", mk(2'd2, 1'b0, 1'b0, 4'd0, 16'h0030));
        cyc(2);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        push_exp("pause_frozen", mk(2'd2, 1'b0, 1'b0, 4'd0, 16'h0030));
        cyc(10);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        door_closed = 1'b1;
        cyc(2);
        press_start();
        push_exp("resume", mk(2'd1, 1'b1, 1'b0, 4'd0, 16'h0030));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        // Prescaler was frozen at 1, so the first tick after resuming is 3 cycles away
        push_exp("resume_tick", mk(2'd1, 1'b1, 1'b0, 4'd0, 16'h0029));
        cyc(3);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        press_stop();
        push_exp("stop_pause", mk(2'd2, 1'b0, 1'b0, 4'd0, 16'h0029));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        press_stop();
        push_exp("stop_set", mk(2'd0, 1'b0, 1'b0, 4'd0, 16'h0000));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
    endtask

    task automatic test_start_ignored();
        do_reset();
        press_start();
        push_exp("start_at_zero", mk(2'd0, 1'b0, 1'b0, 4'd0, 16'h0000));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        key(5);
        door_closed = 1'b0;
        cyc(2);
        press_start();
        push_exp("start_door_open", mk(2'd0, 1'b0, 1'b0, 4'd0, 16'h0005));
        cyc(2);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        door_closed = 1'b1;
        cyc(2);
    endtask

    task automatic test_entry();
        do_reset();
        key(1); key(2); key(3); key(4); key(5);
        push_exp("entry_2345", mk(2'd0, 1'b0, 1'b0, 4'd0, 16'h2345));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        kbd = 10'b0000000110;
        cyc(1);
        kbd = '0;
        cyc(2);
        push_exp("multihot_ignored", mk(2'd0, 1'b0, 1'b0, 4'd0, 16'h2345));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        press_clear();
        push_exp("clear_set", mk(2'd0, 1'b0, 1'b0, 4'd0, 16'h0000));
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
    endtask

    task automatic test_rst_cook();
        do_reset();
        press_pwr();
        key(9);
        press_start();
        push_exp("pre_rst_cook", mk(2'd1, 1'b1, 1'b0, 4'd1, 16'h0009));
        cyc(2);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        rst = 1'b1;
        push_exp("rst_mid_cook", mk(2'd0, 1'b0, 1'b0, 4'd0, 16'h0000));
        cyc(1);
        e = sb_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        else $display("ok   %s %h", e.name, obs);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; kbd = '0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        pwr_key = 1'b0; door_closed = 1'b1;
        test_reset();
        test_countdown();
        test_minutes();
        test_power();
        test_door();
        test_start_ignored();
        test_entry();
        test_rst_cook();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
